// File: rtl/logic_capture_rle.sv
// Logic-analyser capture engine: stores timestamped run-length transition entries into a circular BRAM.
// Define LOGIC_CAPTURE_TRIG_COUNT_EN to add trig_count (fire on the Nth qualifying trigger event).
module logic_capture_rle #(
  parameter int CH     = 8,
  parameter int ADDR_W = 18,
  parameter int TS_W   = 16
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                arm,
  input  logic                                abort,
  input  logic [ADDR_W-1:0]                   pre_count,
  input  logic [CH-1:0]                       trig_mask,
  input  logic [CH-1:0]                       trig_value,
  input  logic [(CH > 1 ? $clog2(CH) : 1)-1:0] trig_ch,
  input  logic                                trig_rise,
`ifdef LOGIC_CAPTURE_TRIG_COUNT_EN
  input  logic [15:0]                         trig_count,
`endif
  input  logic [CH-1:0]                       datain,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [TS_W+CH-1:0]                  mem_wdata,
  output logic                                mem_we,
  output logic                                busy,
  output logic                                triggered,
  output logic                                done,
  output logic                                wrapped,
  output logic [ADDR_W-1:0]                   trig_addr
);

  typedef enum logic [1:0] {IDLE, PRE, ARMED, POST} state_t;

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            state;
  logic [CH-1:0]     sync, cur, prev;
  logic [TS_W-1:0]   ts;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   pre_cnt, post_cnt;
  logic [ADDR_W:0]   pre_next, post_next, post_target;
  logic              active, ts_full, wr, edge_hit, pattern_ok, qual, fire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync <= '0;
      cur  <= '0;
      prev <= '0;
    end else begin
      sync <= datain;
      cur  <= sync;
      prev <= cur;
    end
  end

  assign active      = (state != IDLE);
  assign ts_full     = &ts;
  assign wr          = active && !abort && ((cur != prev) || ts_full);
  assign edge_hit    = trig_rise ? (cur[trig_ch] && !prev[trig_ch]) : (!cur[trig_ch] && prev[trig_ch]);
  assign pattern_ok  = &((cur ~^ trig_value) | ~trig_mask);
  assign qual        = (state == ARMED) && wr && edge_hit && pattern_ok;
  assign pre_next    = pre_cnt + CNT_ONE;
  assign post_next   = post_cnt + CNT_ONE;
  // Post-trigger entries fill whatever the pre-trigger history leaves free.
  assign post_target = DEPTH - {1'b0, pre_count};

`ifdef LOGIC_CAPTURE_TRIG_COUNT_EN
  logic [15:0] evt_cnt;
  logic [15:0] evt_next;
  assign evt_next = evt_cnt + 16'd1;
  assign fire     = qual && (evt_next >= trig_count);
`else
  assign fire = qual;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ts        <= '0;
      ptr       <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      wrapped   <= 1'b0;
      trig_addr <= '0;
`ifdef LOGIC_CAPTURE_TRIG_COUNT_EN
      evt_cnt   <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (state == IDLE) begin
        // Arming always lays down a reference entry at address 0 so decoding starts from a known level.
        if (arm && !abort) begin
          state     <= (pre_count <= ADDR_W'(1)) ? ARMED : PRE;
          busy      <= 1'b1;
          triggered <= 1'b0;
          done      <= 1'b0;
          wrapped   <= 1'b0;
          trig_addr <= '0;
          mem_we    <= 1'b1;
          mem_addr  <= '0;
          mem_wdata <= {{TS_W{1'b0}}, cur};
          ptr       <= ADDR_W'(1);
          ts        <= '0;
          pre_cnt   <= CNT_ONE;
          post_cnt  <= '0;
`ifdef LOGIC_CAPTURE_TRIG_COUNT_EN
          evt_cnt   <= '0;
`endif
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (wr) begin
        mem_we    <= 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= {ts, cur};
        ptr       <= ptr + ADDR_W'(1);
        ts        <= '0;
        if (&ptr) wrapped <= 1'b1;
        unique case (state)
          PRE: begin
            pre_cnt <= pre_next;
            if (pre_next >= {1'b0, pre_count}) state <= ARMED;
          end
          ARMED: begin
            if (fire) begin
              triggered <= 1'b1;
              trig_addr <= ptr;
              post_cnt  <= CNT_ONE;
              if (post_target == CNT_ONE) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= POST;
              end
            end
`ifdef LOGIC_CAPTURE_TRIG_COUNT_EN
            if (qual && !fire) evt_cnt <= evt_next;
`endif
          end
          POST: begin
            post_cnt <= post_next;
            // Completion leaves the sticky done flag and returns straight to idle.
            if (post_next == post_target) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (!ts_full) begin
        ts <= ts + TS_W'(1);
      end
    end
  end

endmodule
